// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin front end of the 8:1 one-bit mux.
// Contents:
//   N_REQ / SEL_W  - requester count and select width
//   arb_state_t    - arbiter state encoding
//   onehot_to_idx  - converts a one-hot vector to its bit index
package mux_arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Index of the set bit; a zero vector yields 0.
    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = idx | SEL_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder.
// Picks the first set bit of (req & ~mask) scanning ptr, ptr+1, ... ptr+7 mod 8.
// Ports:
//   req   in  8  request vector
//   ptr   in  3  highest-priority index
//   mask  in  8  bits excluded from this decision
//   found out 1  at least one eligible request
//   idx   out 3  selected index (valid when found)
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    input  logic [N_REQ-1:0] mask,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [N_REQ-1:0]   elig;
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [N_REQ-1:0]   first;

    always_comb begin
        elig  = req & ~mask;
        // Rotate so that bit 0 of rot corresponds to index ptr.
        dbl   = {elig, elig};
        rot   = dbl[{1'b0, ptr} +: N_REQ];
        // Isolate the lowest set bit of the rotated vector.
        first = rot & (~rot + N_REQ'(1));
        found = |rot;
        // Adding ptr back undoes the rotation; 3-bit wrap gives the mod 8.
        idx   = ptr + onehot_to_idx(first);
    end

endmodule

// File: rtl/mux_8_1_rr_arbiter.sv
// Round-robin arbiter driving the select lines of the cascaded 8:1 mux.
// Grants one requester at a time, forces rotation after MAX_HOLD cycles
// while others are waiting (MAX_HOLD = 0 disables the limit).
// Ports:
//   clk       in  1  clock, rising edge
//   rst_n     in  1  synchronous active-low reset
//   req       in  8  per-source request (bit k <-> mux input Ik)
//   gnt       out 8  registered one-hot grant, zero when idle
//   S0,S1,S2  out 1  registered mux select, {S2,S1,S0} = granted index
//   valid     out 1  a grant is active
//   busy      out 1  a grant is active and another request is pending
module mux_8_1_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             S0,
    output logic             S1,
    output logic             S2,
    output logic             valid,
    output logic             busy
);

    localparam int unsigned CNT_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

    arb_state_t       state, state_n;
    logic [N_REQ-1:0] gnt_n;
    logic [SEL_W-1:0] sel, sel_n;
    logic [SEL_W-1:0] ptr, ptr_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic             take;

    // The current grant doubles as the mask: in IDLE it is zero, and on a
    // switch it keeps the releasing/rotated-out owner out of the decision.
    rr_pick u_pick (
        .req   (req),
        .ptr   (ptr),
        .mask  (gnt),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= '0;
            sel   <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            sel   <= sel_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        sel_n   = sel;
        ptr_n   = ptr;
        cnt_n   = cnt;
        take    = 1'b0;

        case (state)
            IDLE: begin
                take = pick_found;
            end
            GRANT: begin
                if (req[sel]) begin
                    if (MAX_HOLD != 0 && cnt == HOLD_MAX && pick_found) begin
                        take = 1'b1;
                    end else if (cnt < HOLD_MAX) begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end else if (pick_found) begin
                    take = 1'b1;
                end else begin
                    // Select lines keep the last owner while idle.
                    state_n = IDLE;
                    gnt_n   = '0;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase

        if (take) begin
            state_n = GRANT;
            gnt_n   = N_REQ'(1) << pick_idx;
            sel_n   = pick_idx;
            ptr_n   = pick_idx + SEL_W'(1);
            cnt_n   = CNT_W'(1);
        end
    end

    assign {S2, S1, S0} = sel;
    assign valid        = (state == GRANT);
    assign busy         = valid && |(req & ~gnt);

endmodule

// File: doc/mux_8_1_rr_arbiter.md
# mux_8_1_rr_arbiter

Round-robin arbiter that shares the single output of the cascaded 8:1 one-bit mux among eight requesters. It accepts per-source requests, grants one source at a time, and drives the mux select lines S0/S1/S2 so that `out1` carries the granted source. A hold limit forces rotation when other sources are waiting, so no source is starved. The block sits directly in front of the 8:1 mux; the mux itself is unchanged.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive grant cycles per owner while another request is pending. 0 means no limit.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, **synchronous, active-low**.
- `req`  in  8  request from source k (bit k corresponds to mux input Ik).
- `gnt`  out  8  one-hot grant, registered; all-zero when idle.
- `S0`, `S1`, `S2`  out  1 each  mux select, registered; `{S2,S1,S0}` equals the granted index.
- `valid`  out  1  high when a grant is active, meaning mux `out1` is meaningful.
- `busy`  out  1  high when a grant is active and at least one other `req` bit is pending.

## Operation
- The block has two states:
  - IDLE: no grant.
  - GRANT: exactly one `gnt` bit is set.
- Priority pointer `ptr` (3 bits) names the highest-priority index. Selection picks the first set `req` bit scanning `ptr, ptr+1, …, ptr+7` mod 8.
- IDLE → GRANT: when any `req` bit is set. The selected index k becomes owner, `ptr` ← k+1 mod 8, hold counter ← 1.
- GRANT, owner `req` still high:
  - If the hold counter equals `MAX_HOLD` (and `MAX_HOLD`≠0) and another request is pending, rotate directly to the next selected requester. `ptr` and the counter update as on a new grant.
  - Otherwise keep the current owner. The counter increments, saturating at `MAX_HOLD`.
- GRANT, owner `req` low:
  - If any other request is pending, switch directly to it with no idle cycle.
  - Otherwise go to IDLE.
- A switch never grants the releasing or rotated-out owner in the same decision, even if it re-raises `req`. Its bit is masked for that cycle only.
- Select lines hold the last owner index while in IDLE. They change only on the same edge as `gnt`, so `out1` never sees an unrelated source mid-grant.
- `busy` is combinational from registered state and the current `req`.
- Reset values: `gnt`=0, `{S2,S1,S0}`=000, `valid`=0, `busy`=0, `ptr`=0, counter=0, state IDLE.

## Timing
- Grant latency is 1 cycle. A `req` sampled at edge n produces `gnt`/`S`/`valid` after edge n+1 (visible in cycle n+1).
- Release latency is 1 cycle. An owner dropping `req` at edge n loses `gnt` after edge n+1. The next owner's `gnt` appears on that same edge.
- With `MAX_HOLD`=M and continuous contention, each owner holds exactly M cycles.
- Boundary conditions:
  - Simultaneous requests: the lowest index at or after `ptr` wins.
  - Pointer wrap: 7+1 → 0.
  - `req` = 0xFF continuously: grants go 0,1,…,7,0 in order, M cycles each.
  - Reset asserted mid-grant: all outputs reach reset values after that edge, regardless of `req`.
  - `req` glitches between edges are ignored; only edge-sampled values matter.
- The mux path is combinational. `out1` settles within the mux delay after the `S` edge.

## Structure
- Package `mux_arb_pkg` holds:
  - `N_REQ`=8 and `SEL_W`=3.
  - The state enum (IDLE, GRANT).
  - The one-hot-to-index helper function.
- Sub-module `rr_pick`: combinational rotating priority encoder. Inputs are `req` (8), `ptr` (3), and `mask` (8). Outputs are `found` and `idx` (3).
- The top level holds the state register, owner, counter, and `ptr`.

## Test plan
- Reset: `rst_n`=0 for 2 cycles with `req`=0xFF. Required: `gnt`=0, S=000, `valid`=0 throughout. After release, `gnt`=0x01 one cycle later.
- Single requester: `req`=0x20 for 10 cycles, then 0. Required: `gnt`=0x20, S=101, `valid`=1 from cycle 1 through 10, and `out1` tracks I5. Then `gnt`=0 with S held at 101.
- Full contention with `MAX_HOLD`=4 and `req`=0xFF. Required: the grant sequence is 0x01,0x02,…,0x80,0x01, each held exactly 4 cycles, and `busy`=1 throughout.
- Release handoff: owner 3 drops `req` while `req` bits 1 and 6 are high and `ptr`=4. Required: the next `gnt`=0x40 on the following edge, with no idle cycle.
- Mid-grant reset: owner 2 is granted, and `rst_n` pulses low for 1 cycle. Required: all outputs at reset values after that edge. Re-arbitration then starts from `ptr`=0.
- `MAX_HOLD`=0 with `req`=0x81 continuously. Required: owner 0 is held indefinitely. When bit 0 drops, `gnt`=0x80 on the next edge.
